// File: rtl/mte_block_packer.sv
// rtl/mte_block_packer.sv - packs a byte stream into N-bit zero-padded blocks, closing early on EOF_CHAR
// Optional build macro MTE_PACK_STATS_EN adds saturating stat_blocks/stat_frames counters.
module mte_block_packer #(
  parameter int          N        = 256,
  parameter logic [7:0]  EOF_CHAR = 8'h03
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              in_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_block,
  output logic [$clog2(N/8):0]    out_count,
  output logic                    out_last
`ifdef MTE_PACK_STATS_EN
  ,
  output logic [15:0]             stat_blocks,
  output logic [15:0]             stat_frames
`endif
);

  localparam int B    = N / 8;
  localparam int IDXW = $clog2(B);
  localparam int CW   = IDXW + 1;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  logic [1:0]      state;
  logic [N-1:0]    fill_buf;
  logic [N-1:0]    fill_next;
  logic [IDXW-1:0] idx;
  logic [CW-1:0]   pend_count;
  logic            pend_last;

  logic            accept;
  logic            is_eof;
  logic            closing;
  logic            drain;
  logic            out_free;
  logic [CW-1:0]   close_count;

  assign in_ready    = (state != S_PEND);
  assign accept      = in_valid && in_ready;
  assign is_eof      = (in_byte == EOF_CHAR);
  assign closing     = accept && (is_eof || (idx == IDXW'(B - 1)));
  assign drain       = out_valid && out_ready;
  assign out_free    = !out_valid || out_ready;
  assign close_count = CW'(idx) + CW'(1);

  // Lanes above idx are always zero, so an EOF close needs no extra masking.
  always_comb begin
    fill_next = fill_buf;
    fill_next[{idx, 3'b000} +: 8] = in_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_EMPTY;
      fill_buf   <= '0;
      idx        <= '0;
      pend_count <= '0;
      pend_last  <= 1'b0;
      out_valid  <= 1'b0;
      out_block  <= '0;
      out_count  <= '0;
      out_last   <= 1'b0;
    end else if (state == S_PEND) begin
      // Pending block replaces the draining one, so out_valid stays high.
      if (drain) begin
        out_block <= fill_buf;
        out_count <= pend_count;
        out_last  <= pend_last;
        fill_buf  <= '0;
        state     <= S_EMPTY;
      end
    end else if (closing) begin
      idx <= '0;
      if (out_free) begin
        out_block <= fill_next;
        out_count <= close_count;
        out_last  <= is_eof;
        out_valid <= 1'b1;
        fill_buf  <= '0;
        state     <= S_EMPTY;
      end else begin
        fill_buf   <= fill_next;
        pend_count <= close_count;
        pend_last  <= is_eof;
        state      <= S_PEND;
      end
    end else begin
      if (accept) begin
        fill_buf <= fill_next;
        idx      <= idx + 1'b1;
        state    <= S_FILL;
      end
      if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MTE_PACK_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_blocks <= '0;
      stat_frames <= '0;
    end else if (drain) begin
      if (stat_blocks != 16'hFFFF) begin
        stat_blocks <= stat_blocks + 16'd1;
      end
      if (out_last && (stat_frames != 16'hFFFF)) begin
        stat_frames <= stat_frames + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mte_block_packer.sv
// tb/tb_mte_block_packer.sv - self-checking bench for mte_block_packer
// Set MTE_PACK_STATS_EN to also exercise the statistics counters.
module tb_mte_block_packer;

  localparam int         N   = 256;
  localparam int         B   = N / 8;
  localparam logic [7:0] EOF = 8'h03;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_byte;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0]         out_block;
  logic [$clog2(B):0]   out_count;
  logic                 out_last;
`ifdef MTE_PACK_STATS_EN
  logic [15:0]          stat_blocks;
  logic [15:0]          stat_frames;
`endif

  mte_block_packer #(.N(N), .EOF_CHAR(EOF)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_count (out_count),
    .out_last  (out_last)
`ifdef MTE_PACK_STATS_EN
    ,
    .stat_blocks (stat_blocks),
    .stat_frames (stat_frames)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] blk;
    int           cnt;
    logic         lst;
  } blk_t;

  typedef struct {
    int         nbytes;
    int         eof_pos;
    logic [7:0] base;
    int         exp_blocks;
    int         exp_cnt;
    logic       exp_last;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  blk_t       exp_q[$];
  blk_t       obs_q[$];
  logic [7:0] cur[$];
  logic       rnd_done;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: bytes accumulate into a list; a block is emitted at B bytes or on EOF.
  task automatic model_push(input logic [7:0] b);
    blk_t e;
    cur.push_back(b);
    if (cur.size() == B || b == EOF) begin
      e.blk = '0;
      foreach (cur[i]) e.blk[8*i +: 8] = cur[i];
      e.cnt = cur.size();
      e.lst = (b == EOF);
      exp_q.push_back(e);
      cur.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   t;
    logic ok;
    t  = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    while (t < 200) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      t++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (ok) model_push(b);
    else    chk("accept_timeout", N'(0), N'(1));
  endtask

  task automatic send_run(input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) send_byte(base + 8'(k));
  endtask

  task automatic check_drain(input string name, output int n, output int lc, output logic ll);
    int   t;
    blk_t e;
    blk_t o;
    t = 0; n = 0; lc = 0; ll = 1'b0;
    while (obs_q.size() < exp_q.size() && t < 5000) begin
      @(posedge clock);
      #1;
      t++;
    end
    idle(4);
    chk({name, "_nblk"}, N'(obs_q.size()), N'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({name, "_block"}, o.blk, e.blk);
      chk({name, "_count"}, N'(o.cnt), N'(e.cnt));
      chk({name, "_last"}, N'(o.lst), N'(e.lst));
      n++;
      lc = o.cnt;
      ll = o.lst;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Monitor: records transfers and checks output stability under backpressure.
  initial begin
    logic hold_v;
    blk_t held;
    hold_v = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          chk("stable_valid", N'(out_valid), N'(1));
          chk("stable_block", out_block, held.blk);
          chk("stable_count", N'(out_count), N'(held.cnt));
          chk("stable_last", N'(out_last), N'(held.lst));
        end
        if (out_valid && out_ready) begin
          blk_t o;
          o.blk = out_block;
          o.cnt = int'(out_count);
          o.lst = out_last;
          obs_q.push_back(o);
        end
        hold_v   = out_valid && !out_ready;
        held.blk = out_block;
        held.cnt = int'(out_count);
        held.lst = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[7];
    int         n;
    int         lc;
    logic       ll;
    logic [7:0] b;

    vt[0] = '{nbytes: 32, eof_pos: -1, base: 8'h10, exp_blocks: 1, exp_cnt: 32, exp_last: 1'b0};
    vt[1] = '{nbytes: 3,  eof_pos: 2,  base: 8'h41, exp_blocks: 1, exp_cnt: 3,  exp_last: 1'b1};
    vt[2] = '{nbytes: 2,  eof_pos: 1,  base: 8'h44, exp_blocks: 1, exp_cnt: 2,  exp_last: 1'b1};
    vt[3] = '{nbytes: 1,  eof_pos: 0,  base: 8'h50, exp_blocks: 1, exp_cnt: 1,  exp_last: 1'b1};
    vt[4] = '{nbytes: 32, eof_pos: 31, base: 8'h60, exp_blocks: 1, exp_cnt: 32, exp_last: 1'b1};
    vt[5] = '{nbytes: 40, eof_pos: -1, base: 8'h80, exp_blocks: 1, exp_cnt: 32, exp_last: 1'b0};
    vt[6] = '{nbytes: 5,  eof_pos: 4,  base: 8'hA8, exp_blocks: 1, exp_cnt: 13, exp_last: 1'b1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", N'(in_ready), N'(1));
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_out_block", out_block, '0);
    chk("rst_out_count", N'(out_count), N'(0));
    chk("rst_out_last", N'(out_last), N'(0));
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    foreach (vt[r]) begin
      for (int k = 0; k < vt[r].nbytes; k++) begin
        b = (k == vt[r].eof_pos) ? EOF : vt[r].base + 8'(k);
        send_byte(b);
      end
      if (vt[r].exp_last || vt[r].nbytes == B)
        chk($sformatf("vec%0d_latency", r), N'(out_valid), N'(1));
      check_drain($sformatf("vec%0d", r), n, lc, ll);
      chk($sformatf("vec%0d_nblocks", r), N'(n), N'(vt[r].exp_blocks));
      chk($sformatf("vec%0d_cnt", r), N'(lc), N'(vt[r].exp_cnt));
      chk($sformatf("vec%0d_lastflag", r), N'(ll), N'(vt[r].exp_last));
      chk($sformatf("vec%0d_idle_valid", r), N'(out_valid), N'(0));
    end

    // Backpressure: two blocks held, input stalls, drain in order.
    out_ready = 1'b0;
    send_run(64, 8'h90);
    chk("bp_in_ready_low", N'(in_ready), N'(0));
    idle(5);
    chk("bp_in_ready_held", N'(in_ready), N'(0));
    chk("bp_first_byte", N'(out_block[7:0]), N'(8'h90));
    out_ready = 1'b1;
    check_drain("bp", n, lc, ll);
    chk("bp_nblocks", N'(n), N'(2));

    // Close and drain on the same edge: no bubble.
    out_ready = 1'b0;
    send_run(32, 8'h20);
    send_run(31, 8'h40);
    out_ready = 1'b1;
    send_byte(8'h5F);
    chk("nobubble_valid", N'(out_valid), N'(1));
    chk("nobubble_byte0", N'(out_block[7:0]), N'(8'h40));
    check_drain("nobubble", n, lc, ll);

    // Randomized stream with random gaps and backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          b = ($urandom_range(0, 9) == 0) ? EOF : 8'($urandom);
          send_byte(b);
        end
        send_byte(EOF);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check_drain("rand", n, lc, ll);

    // Reset mid-fill with an occupied output register.
    out_ready = 1'b0;
    send_run(32, 8'hB0);
    send_run(10, 8'hD0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", N'(in_ready), N'(1));
    chk("midrst_out_valid", N'(out_valid), N'(0));
    chk("midrst_out_block", out_block, '0);
    chk("midrst_out_count", N'(out_count), N'(0));
    chk("midrst_out_last", N'(out_last), N'(0));
    exp_q.delete();
    obs_q.delete();
    cur.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    send_run(32, 8'h10);
    check_drain("postrst", n, lc, ll);
    chk("postrst_nblocks", N'(n), N'(1));

`ifdef MTE_PACK_STATS_EN
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("stats_rst_blocks", N'(stat_blocks), N'(0));
    send_run(39, 8'h10);
    send_byte(EOF);
    send_byte(EOF);
    send_run(36, 8'h60);
    send_byte(EOF);
    check_drain("stats", n, lc, ll);
    chk("stat_blocks", N'(stat_blocks), N'(5));
    chk("stat_frames", N'(stat_frames), N'(3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
